// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle to machine-word encoder with address-tagged output buffer
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter int          DEPTH     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        out_error,
  output logic [15:0] words_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        f7_ok;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        imm21_ok;
  logic        is_shift;

  assign f7_ok    = (in_funct7 == 7'b0000000) || (in_funct7 == 7'b0100000);
  assign imm12_ok = (in_imm[31:12] == {20{in_imm[11]}});
  assign imm13_ok = (in_imm[31:13] == {19{in_imm[12]}});
  assign imm21_ok = (in_imm[31:21] == {11{in_imm[20]}});
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Malformed fields still produce a word from the truncated bits; only the flag marks it.
  always_comb begin
    enc_word = 32'h00000013;
    enc_err  = 1'b0;
    case (in_opcode)
      OP_LUI, OP_AUIPC: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = (in_imm[11:0] != 12'h000);
      end
      OP_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = !imm21_ok || in_imm[0];
      end
      OP_JALR, OP_LOAD: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !imm12_ok;
      end
      OP_IMM: begin
        if (is_shift) begin
          enc_word = {in_funct7, in_shamt, in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = !f7_ok || ((in_funct7 == 7'b0100000) && (in_funct3 == 3'b001));
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = !imm12_ok;
        end
      end
      OP_BRANCH: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = !imm13_ok || in_imm[0];
      end
      OP_STORE: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = !imm12_ok;
      end
      OP_REG: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !f7_ok;
      end
      OP_SYSTEM: begin
        enc_word = 32'h00000073;
        enc_err  = 1'b0;
      end
      default: begin
        enc_word = 32'h00000013;
        enc_err  = 1'b1;
      end
    endcase
  end

  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_addr [DEPTH];
  logic          mem_err  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   addr_cnt;
  logic          full;
  logic          push;
  logic          pop;

  assign full      = (count == FULL_CNT);
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // An empty buffer shows the address the next accepted word will receive.
  assign out_data  = out_valid ? mem_data[rd_ptr] : 32'h0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr] : addr_cnt;
  assign out_error = out_valid ? mem_err[rd_ptr]  : 1'b0;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= enc_word;
      mem_addr[wr_ptr] <= addr_cnt;
      mem_err[wr_ptr]  <= enc_err;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        addr_cnt <= addr_cnt + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The pop counter survives flush so the loader can audit total traffic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      words_out <= 16'h0000;
    end else if (pop && (words_out != 16'hFFFF)) begin
      words_out <= words_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed table-driven bench for instr_encoder
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_error;
  logic [15:0] words_out;

  instr_encoder dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_error(out_error),
    .words_out(words_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_addr;
  vec_t vecs [16];

  function automatic vec_t mk(logic [6:0] op, logic [4:0] rd, logic [2:0] f3, logic [4:0] rs1,
                              logic [4:0] rs2, logic [6:0] f7, logic [31:0] imm, logic [4:0] shamt,
                              logic [31:0] w, logic e);
    vec_t v;
    v.op = op; v.rd = rd; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.f7 = f7;
    v.imm = imm; v.shamt = shamt; v.exp_word = w; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_rd = v.rd; in_funct3 = v.f3; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_funct7 = v.f7; in_imm = v.imm; in_shamt = v.shamt;
  endtask

  // Push one bundle with out_ready=1 and check it at the head one cycle later.
  task automatic send_check(input vec_t v, input string name);
    @(negedge clock);
    drive(v);
    in_valid = 1'b1;
    check({name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    check({name, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({name, ".data"}, out_data, v.exp_word);
    check({name, ".err"}, {31'b0, out_error}, {31'b0, v.exp_err});
    check({name, ".addr"}, out_addr, exp_addr);
    exp_addr = exp_addr + 32'd4;
  endtask

  initial begin
    vec_t a1, a2, a3;
    logic [31:0] got_data [3];
    logic [31:0] got_addr [3];
    int ngot;
    logic [15:0] wsave;
    logic accepted;

    vecs[0]  = mk(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5,        5'd0, 32'h00500093, 1'b0);
    vecs[1]  = mk(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'hFFFFFFF8, 5'd0, 32'hFE208CE3, 1'b0);
    vecs[2]  = mk(7'b0010011, 5'd3, 3'b101, 5'd4, 5'd0, 7'b0100000, 32'd0,  5'd7, 32'h40725193, 1'b0);
    vecs[3]  = mk(7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'h00000800, 5'd0, 32'h001000EF, 1'b0);
    vecs[4]  = mk(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'h00000800, 5'd0, 32'h80000093, 1'b1);
    vecs[5]  = mk(7'h7F,      5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd0,        5'd0, 32'h00000013, 1'b1);
    vecs[6]  = mk(7'b0110111, 5'd5, 3'b000, 5'd0, 5'd0, 7'd0, 32'h12345000, 5'd0, 32'h123452B7, 1'b0);
    vecs[7]  = mk(7'b0110111, 5'd5, 3'b000, 5'd0, 5'd0, 7'd0, 32'h12345001, 5'd0, 32'h123452B7, 1'b1);
    vecs[8]  = mk(7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd12,       5'd0, 32'h0020A623, 1'b0);
    vecs[9]  = mk(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0,        5'd0, 32'h002081B3, 1'b0);
    vecs[10] = mk(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'h7F, 32'd0,       5'd0, 32'hFE2081B3, 1'b1);
    vecs[11] = mk(7'b1110011, 5'd5, 3'b111, 5'd9, 5'd9, 7'h7F, 32'd123,     5'd3, 32'h00000073, 1'b0);
    vecs[12] = mk(7'b0010011, 5'd1, 3'b001, 5'd2, 5'd0, 7'b0100000, 32'd0,  5'd3, 32'h40311093, 1'b1);
    vecs[13] = mk(7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5,        5'd0, 32'h00000263, 1'b1);
    vecs[14] = mk(7'b1101111, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC, 5'd0, 32'hFFDFF06F, 1'b0);
    vecs[15] = mk(7'b0000011, 5'd1, 3'b010, 5'd2, 5'd0, 7'd0, 32'hFFFFFFFF, 5'd0, 32'hFFF12083, 1'b0);
    a1 = mk(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd1, 5'd0, 32'h00100093, 1'b0);
    a2 = mk(7'b0010011, 5'd2, 3'b000, 5'd0, 5'd0, 7'd0, 32'd2, 5'd0, 32'h00200113, 1'b0);
    a3 = mk(7'b0010011, 5'd3, 3'b000, 5'd0, 5'd0, 7'd0, 32'd3, 5'd0, 32'h00300193, 1'b0);

    // Reset state
    #12;
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.data", out_data, 32'd0);
    check("rst.addr", out_addr, BASE);
    check("rst.err", {31'b0, out_error}, 32'd0);
    check("rst.words", {16'b0, words_out}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    exp_addr = BASE;

    for (int i = 0; i < 16; i++) begin
      send_check(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        @(negedge clock);
        check("first.words", {16'b0, words_out}, 32'd1);
      end
    end
    @(negedge clock);
    check("table.words", {16'b0, words_out}, 32'd16);
    check("table.empty", {31'b0, out_valid}, 32'd0);

    // Backpressure: three bundles, only two fit
    out_ready = 1'b0;
    drive(a1); in_valid = 1'b1;
    @(negedge clock);
    drive(a2);
    check("bp.ready2", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    drive(a3);
    check("bp.full", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    check("bp.held", {31'b0, in_ready}, 32'd0);
    check("bp.head", out_data, a1.exp_word);
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 20; c++) begin
      accepted = in_valid && in_ready;
      if (out_valid && out_ready && ngot < 3) begin
        got_data[ngot] = out_data;
        got_addr[ngot] = out_addr;
        ngot++;
      end
      @(negedge clock);
      if (accepted) in_valid = 1'b0;
    end
    check("bp.count", ngot, 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < ngot) begin
        check($sformatf("bp.addr%0d", k), got_addr[k], exp_addr + 32'(4 * k));
      end
    end
    if (ngot > 0) check("bp.data0", got_data[0], a1.exp_word);
    if (ngot > 1) check("bp.data1", got_data[1], a2.exp_word);
    if (ngot > 2) check("bp.data2", got_data[2], a3.exp_word);
    check("bp.drained", {31'b0, out_valid}, 32'd0);
    check("bp.words", {16'b0, words_out}, 32'd19);

    // Flush with a full buffer and a bundle on offer
    out_ready = 1'b0;
    drive(a1); in_valid = 1'b1;
    @(negedge clock);
    drive(a2);
    @(negedge clock);
    check("fl.full", {31'b0, out_valid}, 32'd1);
    wsave = words_out;
    drive(a3);
    flush = 1'b1;
    check("fl.ready", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    check("fl.valid", {31'b0, out_valid}, 32'd0);
    check("fl.addr", out_addr, BASE);
    check("fl.words", {16'b0, words_out}, {16'b0, wsave});
    out_ready = 1'b1;
    exp_addr = BASE;
    send_check(vecs[0], "fl.next");

    // Asynchronous reset mid-stream
    @(negedge clock);
    out_ready = 1'b0;
    drive(a1); in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("ar.pre", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar.valid", {31'b0, out_valid}, 32'd0);
    check("ar.data", out_data, 32'd0);
    check("ar.addr", out_addr, BASE);
    check("ar.err", {31'b0, out_error}, 32'd0);
    check("ar.words", {16'b0, words_out}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
